// File: rtl/fdt_search_engine_if.sv
// Handshake bundle between the dispatcher, the FDT search engine and the AT tree.
// master: dispatcher/AT side (drives requests and row updates)
// slave : search engine (drives ready, grants and per-class blocked flags)
// REQ_ID_WIDTH sets the default request id width (8 when not defined).

`ifndef REQ_ID_WIDTH
`define REQ_ID_WIDTH 8
`endif

interface fdt_search_engine_if #(
   parameter int ROWS        = 64,
   parameter int NUM_CLASSES = 4,
   parameter int ID_W        = `REQ_ID_WIDTH
);
   localparam int IDX_W = $clog2(ROWS);
   localparam int CLS_W = $clog2(NUM_CLASSES);

   logic                   alloc_valid_dsp_in;
   logic                   alloc_ready_dsp_out;
   logic [ID_W-1:0]        alloc_id_dsp_in;
   logic [CLS_W-1:0]       alloc_size_dsp_in;

   logic                   alloc_valid_at_out;
   logic [ID_W-1:0]        alloc_id_at_out;
   logic [IDX_W-1:0]       alloc_row_index_at_out;
   logic [CLS_W-1:0]       alloc_size_at_out;

   logic                   fdt_update_valid_at_in;
   logic [IDX_W-1:0]       fdt_update_idx_at_in;
   logic [NUM_CLASSES-1:0] fdt_update_bit_sequence_at_in;

   logic [NUM_CLASSES-1:0] fdt_blocked_out;

   modport master (
      output alloc_valid_dsp_in, alloc_id_dsp_in, alloc_size_dsp_in,
      input  alloc_ready_dsp_out,
      input  alloc_valid_at_out, alloc_id_at_out, alloc_row_index_at_out, alloc_size_at_out,
      output fdt_update_valid_at_in, fdt_update_idx_at_in, fdt_update_bit_sequence_at_in,
      input  fdt_blocked_out
   );

   modport slave (
      input  alloc_valid_dsp_in, alloc_id_dsp_in, alloc_size_dsp_in,
      output alloc_ready_dsp_out,
      output alloc_valid_at_out, alloc_id_at_out, alloc_row_index_at_out, alloc_size_at_out,
      input  fdt_update_valid_at_in, fdt_update_idx_at_in, fdt_update_bit_sequence_at_in,
      output fdt_blocked_out
   );
endinterface

// File: rtl/fdt_search_engine.sv
// Free-descriptor table search engine between the dispatcher and the AT tree.
// Keeps one occupancy vector per size class plus a shared in-flight mask, grants
// one free row per request (one grant per cycle sustained) and applies AT row updates.
// Optional feature: define FDT_NEXT_FIT_EN for per-class next-fit search pointers;
// otherwise the lowest free row is always chosen.
//
// S0 request stage states:
//   state     | meaning
//   S0_EMPTY  | no request held, ready high
//   S0_HELD   | request held; searched every cycle until a row is found

`ifndef REQ_ID_WIDTH
`define REQ_ID_WIDTH 8
`endif

module fdt_search_engine #(
   parameter int ROWS        = 64,
   parameter int NUM_CLASSES = 4,
   parameter int ID_W        = `REQ_ID_WIDTH
) (
   input logic                clk,
   input logic                rst_n,
   fdt_search_engine_if.slave bus
);
   localparam int IDX_W = $clog2(ROWS);
   localparam int CLS_W = $clog2(NUM_CLASSES);

   typedef enum logic {S0_EMPTY, S0_HELD} s0_state_t;

   s0_state_t                         state_q, state_d;
   logic                              s0_valid;
   logic [ID_W-1:0]                   s0_id;
   logic [CLS_W-1:0]                  s0_cls;

   logic [NUM_CLASSES-1:0][ROWS-1:0]  tbl_q;
   logic [ROWS-1:0]                   mask_q;

   logic                              ready;
   logic                              cls_ok;
   logic                              load;
   logic [ROWS-1:0]                   cand;
   logic [IDX_W-1:0]                  search_start;
   logic                              found;
   logic [IDX_W-1:0]                  grant_row;
   logic                              s0_grant;
   logic [ROWS-1:0]                   grant_onehot;
   logic [ROWS-1:0]                   upd_onehot;

   // out-of-range classes are accepted but never enter S0
   assign cls_ok = (32'(bus.alloc_size_dsp_in) < NUM_CLASSES);
   assign load   = bus.alloc_valid_dsp_in & ready & cls_ok;

   // S0 state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S0_EMPTY;
      else        state_q <= state_d;
   end

   // S0 next state: a held request leaves only on grant; a new one may replace it the same cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         S0_EMPTY: if (load) state_d = S0_HELD;
         S0_HELD:  if (found) state_d = load ? S0_HELD : S0_EMPTY;
         default:  state_d = S0_EMPTY;
      endcase
   end

   // S0 outputs: ready frees up in the same cycle the held request is granted
   always_comb begin
      s0_valid = (state_q == S0_HELD);
      s0_grant = s0_valid & found;
      ready    = ~s0_valid | s0_grant;
      bus.alloc_ready_dsp_out = ready;
   end

   // S0 payload capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_id  <= '0;
         s0_cls <= '0;
      end else if (load) begin
         s0_id  <= bus.alloc_id_dsp_in;
         s0_cls <= bus.alloc_size_dsp_in;
      end
   end

   // candidate rows: full for this class or already granted and awaiting AT update
   assign cand = tbl_q[s0_cls] | mask_q;

`ifdef FDT_NEXT_FIT_EN
   logic [NUM_CLASSES-1:0][IDX_W-1:0] ptr_q;

   assign search_start = ptr_q[s0_cls];

   // per-class next-fit pointer, advanced past each granted row (wraps naturally, ROWS is 2^n)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        ptr_q <= '0;
      else if (s0_grant) ptr_q[s0_cls] <= grant_row + IDX_W'(1);
   end
`else
   assign search_start = '0;
`endif

   // first zero of cand at or after search_start, wrapping modulo ROWS
   always_comb begin
      logic [IDX_W-1:0] probe;
      probe     = '0;
      found     = 1'b0;
      grant_row = '0;
      for (int i = 0; i < ROWS; i++) begin
         probe = search_start + IDX_W'(i);
         if (!found && !cand[probe]) begin
            found     = 1'b1;
            grant_row = probe;
         end
      end
   end

   assign grant_onehot = ROWS'(s0_grant) << grant_row;
   assign upd_onehot   = ROWS'(bus.fdt_update_valid_at_in) << bus.fdt_update_idx_at_in;

   // in-flight mask: update clears, grant sets; grant wins on the same row
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mask_q <= '0;
      else        mask_q <= (mask_q & ~upd_onehot) | grant_onehot;
   end

   // AT update rewrites the row's full bit for every class at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tbl_q <= '0;
      end else if (bus.fdt_update_valid_at_in) begin
         for (int c = 0; c < NUM_CLASSES; c++)
            tbl_q[c][bus.fdt_update_idx_at_in] <= bus.fdt_update_bit_sequence_at_in[c];
      end
   end

   // grant output registers: valid is a one-cycle pulse, payload holds until the next grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.alloc_valid_at_out     <= 1'b0;
         bus.alloc_id_at_out        <= '0;
         bus.alloc_row_index_at_out <= '0;
         bus.alloc_size_at_out      <= '0;
      end else begin
         bus.alloc_valid_at_out <= s0_grant;
         if (s0_grant) begin
            bus.alloc_id_at_out        <= s0_id;
            bus.alloc_row_index_at_out <= grant_row;
            bus.alloc_size_at_out      <= s0_cls;
         end
      end
   end

   // class is blocked when every row is either full for it or in flight
   always_comb begin
      bus.fdt_blocked_out = '0;
      for (int c = 0; c < NUM_CLASSES; c++)
         bus.fdt_blocked_out[c] = &(tbl_q[c] | mask_q);
   end

endmodule
